// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the water-quality fuzzy inference blocks.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StSelect,
        StDone
    } state_e;

    localparam int unsigned DefNumSets = 7;
    localparam int unsigned DefIdW     = 8;
    localparam int unsigned DefMuW     = 8;

    // Rule-map mode encodings
    localparam logic ModeInverted = 1'b0;  // k -> NUM_SETS+1-k
    localparam logic ModeDirect   = 1'b1;  // k -> k

    // Set IDs are 1-based; 0 and anything above the universe size are invalid
    function automatic logic id_is_invalid(input int unsigned id, input int unsigned num_sets);
        return (id == 0) || (id > num_sets);
    endfunction

endpackage

// File: rtl/fuzzy_rule_map.sv
// Combinational antecedent-to-consequent set mapping with validity flag.
module fuzzy_rule_map
    import fuzzy_pkg::*;
#(
    parameter int unsigned NUM_SETS = DefNumSets,
    parameter int unsigned ID_W     = DefIdW
) (
    input  logic [ID_W-1:0] id_i,
    input  logic            mode_i,
    output logic [ID_W-1:0] cons_id_o,
    output logic            valid_o
);

    // Consequent is meaningless when valid_o is low; callers must gate on it
    always_comb begin
        valid_o = !id_is_invalid(32'(id_i), NUM_SETS);
        if (mode_i == ModeDirect) begin
            cons_id_o = id_i;
        end else begin
            cons_id_o = ID_W'(NUM_SETS + 1) - id_i;
        end
    end

endmodule

// File: rtl/fuzzy_rule_engine.sv
// Multi-channel Mamdani rule engine: maps each channel's antecedent set to a
// consequent set, max-aggregates strengths per output set, then picks the
// dominant set (lowest ID wins ties).
module fuzzy_rule_engine
    import fuzzy_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned NUM_SETS   = DefNumSets,
    parameter int unsigned ID_W       = DefIdW,
    parameter int unsigned MU_W       = DefMuW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_INPUTS*ID_W-1:0] in_set_id_i,
    input  logic [NUM_INPUTS*MU_W-1:0] in_mu_i,
    input  logic                     mode_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ID_W-1:0]          out_set_id_o,
    output logic [NUM_SETS*MU_W-1:0] out_strength_o,
    output logic                     out_err_o
);

    // Wide enough for channel index 0..15 and set index 1..15
    localparam int unsigned CntW = 5;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [NUM_INPUTS*ID_W-1:0] set_id_q, set_id_d;
    logic [NUM_INPUTS*MU_W-1:0] mu_q, mu_d;
    logic                       mode_q, mode_d;
    logic [MU_W-1:0]            acc_q [NUM_SETS];
    logic [MU_W-1:0]            acc_d [NUM_SETS];
    logic                       err_q, err_d;
    logic [ID_W-1:0]            best_id_q, best_id_d;
    logic [MU_W-1:0]            best_mu_q, best_mu_d;
    logic [ID_W-1:0]            out_set_id_q, out_set_id_d;
    logic [NUM_SETS*MU_W-1:0]   out_strength_q, out_strength_d;
    logic                       out_err_q, out_err_d;

    logic [ID_W-1:0] ch_id;
    logic [MU_W-1:0] ch_mu;
    logic [ID_W-1:0] ch_cons;
    logic            ch_valid;
    logic [MU_W-1:0] sel_mu;

    // Select the channel under evaluation and the set under comparison
    always_comb begin
        ch_id  = '0;
        ch_mu  = '0;
        sel_mu = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (cnt_q == CntW'(i)) begin
                ch_id = set_id_q[i*ID_W +: ID_W];
                ch_mu = mu_q[i*MU_W +: MU_W];
            end
        end
        for (int s = 0; s < NUM_SETS; s++) begin
            if (cnt_q == CntW'(s + 1)) begin
                sel_mu = acc_q[s];
            end
        end
    end

    fuzzy_rule_map #(
        .NUM_SETS (NUM_SETS),
        .ID_W     (ID_W)
    ) u_rule_map (
        .id_i      (ch_id),
        .mode_i    (mode_q),
        .cons_id_o (ch_cons),
        .valid_o   (ch_valid)
    );

    // Next-state logic: accept, evaluate channels, select dominant set, hold result
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        set_id_d       = set_id_q;
        mu_d           = mu_q;
        mode_d         = mode_q;
        acc_d          = acc_q;
        err_d          = err_q;
        best_id_d      = best_id_q;
        best_mu_d      = best_mu_q;
        out_set_id_d   = out_set_id_q;
        out_strength_d = out_strength_q;
        out_err_d      = out_err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    set_id_d = in_set_id_i;
                    mu_d     = in_mu_i;
                    mode_d   = mode_i;
                    for (int s = 0; s < NUM_SETS; s++) begin
                        acc_d[s] = '0;
                    end
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                if (!ch_valid) begin
                    err_d = 1'b1;
                end else begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        if (ch_cons == ID_W'(s + 1) && ch_mu > acc_q[s]) begin
                            acc_d[s] = ch_mu;
                        end
                    end
                end
                if (cnt_q == CntW'(NUM_INPUTS - 1)) begin
                    cnt_d     = CntW'(1);
                    best_id_d = '0;
                    best_mu_d = '0;
                    state_d   = StSelect;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSelect: begin
                // Strict compare keeps the lower set ID on ties
                if (sel_mu > best_mu_q) begin
                    best_id_d = ID_W'(cnt_q);
                    best_mu_d = sel_mu;
                end
                if (cnt_q == CntW'(NUM_SETS)) begin
                    out_set_id_d = best_id_d;
                    for (int s = 0; s < NUM_SETS; s++) begin
                        out_strength_d[s*MU_W +: MU_W] = acc_q[s];
                    end
                    out_err_d = err_q;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            set_id_q       <= '0;
            mu_q           <= '0;
            mode_q         <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                acc_q[s] <= '0;
            end
            err_q          <= 1'b0;
            best_id_q      <= '0;
            best_mu_q      <= '0;
            out_set_id_q   <= '0;
            out_strength_q <= '0;
            out_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            set_id_q       <= set_id_d;
            mu_q           <= mu_d;
            mode_q         <= mode_d;
            acc_q          <= acc_d;
            err_q          <= err_d;
            best_id_q      <= best_id_d;
            best_mu_q      <= best_mu_d;
            out_set_id_q   <= out_set_id_d;
            out_strength_q <= out_strength_d;
            out_err_q      <= out_err_d;
        end
    end

    assign in_ready_o     = (state_q == StIdle);
    assign out_valid_o    = (state_q == StDone);
    assign out_set_id_o   = out_set_id_q;
    assign out_strength_o = out_strength_q;
    assign out_err_o      = out_err_q;

endmodule

// File: tb/tb_fuzzy_rule_engine.sv
// Self-checking bench for fuzzy_rule_engine at default parameters.
module tb_fuzzy_rule_engine;

    localparam int NI  = 2;
    localparam int NS  = 7;
    localparam int IW  = 8;
    localparam int MW  = 8;
    localparam int IDV = NI * IW;
    localparam int MUV = NI * MW;
    localparam int STV = NS * MW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [IDV-1:0] in_set_id = '0;
    logic [MUV-1:0] in_mu = '0;
    logic           mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [IW-1:0]  out_set_id;
    logic [STV-1:0] out_strength;
    logic           out_err;

    int n_asserts = 0;
    int n_fail = 0;

    fuzzy_rule_engine #(
        .NUM_INPUTS (NI),
        .NUM_SETS   (NS),
        .ID_W       (IW),
        .MU_W       (MW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_set_id_i    (in_set_id),
        .in_mu_i        (in_mu),
        .mode_i         (mode),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_set_id_o   (out_set_id),
        .out_strength_o (out_strength),
        .out_err_o      (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: max-aggregate per consequent set, then lowest set holding the maximum
    task automatic model(input logic [IDV-1:0] ids, input logic [MUV-1:0] mus, input logic md,
                         output logic [STV-1:0] e_str, output logic [IW-1:0] e_id,
                         output logic e_err);
        int acc[NS+1];
        int id, mu, c, maxv;
        foreach (acc[k]) acc[k] = 0;
        e_err = 1'b0;
        for (int ch = 0; ch < NI; ch++) begin
            id = int'(ids[ch*IW +: IW]);
            mu = int'(mus[ch*MW +: MW]);
            if (id < 1 || id > NS) begin
                e_err = 1'b1;
            end else begin
                c = md ? id : NS + 1 - id;
                if (mu > acc[c]) acc[c] = mu;
            end
        end
        maxv = 0;
        for (int s = 1; s <= NS; s++) if (acc[s] > maxv) maxv = acc[s];
        e_id = '0;
        if (maxv > 0) begin
            for (int s = NS; s >= 1; s--) if (acc[s] == maxv) e_id = IW'(s);
        end
        e_str = '0;
        for (int s = 1; s <= NS; s++) e_str[(s-1)*MW +: MW] = MW'(acc[s]);
    endtask

    task automatic chk_result(input string tag, input logic [STV-1:0] e_str,
                              input logic [IW-1:0] e_id, input logic e_err);
        chk({tag, ":set_id"}, 64'(out_set_id), 64'(e_id));
        chk({tag, ":strength"}, 64'(out_strength), 64'(e_str));
        chk({tag, ":err"}, 64'(out_err), 64'(e_err));
    endtask

    // Accept one vector, wait for its result, check latency and contents, consume it
    task automatic run_vec(input logic [IDV-1:0] ids, input logic [MUV-1:0] mus,
                           input logic md, input bit early, input string tag);
        logic [STV-1:0] e_str;
        logic [IW-1:0]  e_id;
        logic           e_err;
        int             lat;
        model(ids, mus, md, e_str, e_id, e_err);
        chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        in_set_id = ids;
        in_mu     = mus;
        mode      = md;
        in_valid  = 1'b1;
        out_ready = early;
        tick();
        in_valid  = 1'b0;
        in_set_id = IDV'($urandom);
        in_mu     = MUV'($urandom);
        mode      = 1'($urandom);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 50);
        chk({tag, ":latency"}, 64'(lat), 64'(NI + NS));
        chk_result(tag, e_str, e_id, e_err);
        chk({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ":in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [STV-1:0] e_str;
        logic [IW-1:0]  e_id;
        logic           e_err;
        logic [IDV-1:0] ids;
        logic [MUV-1:0] mus;
        int             lat;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst:in_ready", 64'(in_ready), 64'd1);
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk_result("rst", '0, '0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_vec({8'd4, 8'd1}, {8'd90, 8'd200}, 1'b0, 1'b0, "inv_1_4");
        run_vec({8'd3, 8'd3}, {8'd120, 8'd50}, 1'b0, 1'b0, "max_not_sum");
        run_vec({8'd6, 8'd2}, {8'd100, 8'd100}, 1'b1, 1'b0, "tie_low");
        run_vec({8'd9, 8'd0}, {8'd77, 8'd33}, 1'b0, 1'b0, "invalid_ids");
        run_vec({8'd5, 8'd7}, {8'd0, 8'd0}, 1'b1, 1'b1, "zero_mu_early");

        // Hold result with OUT_READY low; new inputs must be ignored
        ids = {8'd5, 8'd2};
        mus = {8'd180, 8'd60};
        model(ids, mus, 1'b1, e_str, e_id, e_err);
        in_set_id = ids;
        in_mu = mus;
        mode = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 50);
        chk("hold:latency", 64'(lat), 64'(NI + NS));
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_set_id = IDV'($urandom);
            in_mu     = MUV'($urandom);
            mode      = 1'($urandom);
            tick();
            chk("hold:valid", 64'(out_valid), 64'd1);
            chk("hold:in_ready", 64'(in_ready), 64'd0);
            chk_result("hold", e_str, e_id, e_err);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold:release_in_ready", 64'(in_ready), 64'd1);
        chk("hold:release_valid", 64'(out_valid), 64'd0);

        // Leave a non-zero result held, then reset mid-SELECT
        run_vec({8'd4, 8'd1}, {8'd90, 8'd200}, 1'b0, 1'b0, "pre_rst");
        in_set_id = {8'd2, 8'd1};
        in_mu = {8'd20, 8'd10};
        mode = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (NI + 2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst:in_ready", 64'(in_ready), 64'd1);
        chk("midrst:out_valid", 64'(out_valid), 64'd0);
        chk_result("midrst", '0, '0, 1'b0);
        run_vec({8'd7, 8'd2}, {8'd33, 8'd250}, 1'b1, 1'b0, "post_rst");

        // Randomized vectors against the reference model
        for (int n = 0; n < 24; n++) begin
            for (int ch = 0; ch < NI; ch++) begin
                ids[ch*IW +: IW] = IW'($urandom_range(0, 9));
                mus[ch*MW +: MW] = ($urandom_range(0, 3) == 0) ? '0
                                   : MW'($urandom_range(1, 255));
            end
            run_vec(ids, mus, 1'($urandom), 1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
